dmx_universe_scheduler: RTL

- Owns a double-buffered 512-slot DMX universe and feeds the packetizer's slot_byte from the front bank, indexed by the packetizer's slot_count.
- Host logic (UART command decoder) writes the back bank and requests a commit. The bank swap is deferred to the next frame start, so no transmitted frame ever mixes old and new data.
- Also provides frame counting, blackout override, and a stale-data watchdog.

---
 rtl/dmx_universe_scheduler_pkg.sv | 22 ++
 rtl/dmx_universe_scheduler_if.sv | 24 ++
 rtl/dmx_universe_ram.sv | 20 ++
 rtl/dmx_universe_scheduler.sv | 110 +++++++++++
 4 files changed

// File: rtl/dmx_universe_scheduler_pkg.sv
// Shared constants and types for the DMX universe scheduler.
// The baud divider is kept here so the packetizer and scheduler agree on it.
package dmx_universe_scheduler_pkg;

  localparam int SLOT_ADDR_W        = 10;
  localparam int DEF_NUM_SLOTS      = 512;
  localparam int DEF_STALE_FRAMES   = 44;
  localparam bit DEF_STALE_BLACKOUT = 1'b1;
  localparam int BAUD_DIV           = 48;

  typedef enum logic {
    S_CM_IDLE    = 1'b0,
    S_CM_PENDING = 1'b1
  } cm_state_e;

  // RAM address is {bank, slot}; slot indices below 512 fit in the low 9 bits.
  function automatic logic [SLOT_ADDR_W-1:0] bank_addr(input logic bank,
                                                       input logic [SLOT_ADDR_W-2:0] slot);
    return {bank, slot};
  endfunction

endpackage

// File: rtl/dmx_universe_scheduler_if.sv
// Packetizer read bus and host write/commit bus of the universe scheduler.
interface dmx_universe_scheduler_if;
  import dmx_universe_scheduler_pkg::*;

  logic [SLOT_ADDR_W-1:0] slot_count;
  logic [7:0]             slot_byte;
  logic                   wr_en;
  logic [SLOT_ADDR_W-1:0] wr_addr;
  logic [7:0]             wr_data;
  logic                   wr_ready;
  logic                   commit_req;
  logic                   commit_done;

  modport master (
    output slot_count, wr_en, wr_addr, wr_data, commit_req,
    input  slot_byte, wr_ready, commit_done
  );

  modport slave (
    input  slot_count, wr_en, wr_addr, wr_data, commit_req,
    output slot_byte, wr_ready, commit_done
  );

endinterface

// File: rtl/dmx_universe_ram.sv
// 1024x8 simple dual-port RAM, one write port and one registered read port.
// No reset on the array or read register so it maps onto iCE40 block RAM.
module dmx_universe_ram (
  input  logic       clk,
  input  logic       we,
  input  logic [9:0] waddr,
  input  logic [7:0] wdata,
  input  logic [9:0] raddr,
  output logic [7:0] rdata
);

  logic [7:0] mem [0:1023];

  // Write port plus synchronous read.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/dmx_universe_scheduler.sv
// Double-buffered DMX universe: host fills the back bank, the swap is
// deferred to the next frame start, and the front bank feeds the packetizer.
//
// state        | meaning
// -------------+----------------------------------------------------
// S_CM_IDLE    | host writes accepted, waiting for commit_req
// S_CM_PENDING | commit requested, writes blocked until frame start
module dmx_universe_scheduler
  import dmx_universe_scheduler_pkg::*;
#(
  parameter int NUM_SLOTS      = DEF_NUM_SLOTS,
  parameter int STALE_FRAMES   = DEF_STALE_FRAMES,
  parameter bit STALE_BLACKOUT = DEF_STALE_BLACKOUT
) (
  input  logic                            CLK12,
  input  logic                            reset,
  dmx_universe_scheduler_if.slave         bus,
  input  logic                            blackout,
  output logic                            stale,
  output logic                            wr_overrun,
  output logic [15:0]                     frame_count
);

  localparam logic [SLOT_ADDR_W-1:0] SLOT_END  = SLOT_ADDR_W'(NUM_SLOTS);
  localparam logic [SLOT_ADDR_W-1:0] SLOT_ONE  = SLOT_ADDR_W'(1);
  localparam int                     STALE_W   = $clog2(STALE_FRAMES + 1);
  localparam logic [STALE_W-1:0]     STALE_MAX = STALE_W'(STALE_FRAMES);

  cm_state_e              state, state_nxt;
  logic                   front;
  logic [SLOT_ADDR_W-1:0] prev_slot;
  logic [STALE_W-1:0]     stale_cnt;
  logic                   frame_start;
  logic                   swap;
  logic                   wr_ready;
  logic                   wr_accept;
  logic                   rd_zero;
  logic [7:0]             ram_q;

  assign frame_start = (bus.slot_count == SLOT_ONE) && (prev_slot != SLOT_ONE);
  assign wr_ready    = (state == S_CM_IDLE);
  assign wr_accept   = bus.wr_en && wr_ready &&
                       (bus.wr_addr != '0) && (bus.wr_addr < SLOT_END);

  assign bus.wr_ready    = wr_ready;
  assign bus.commit_done = swap;
  // Zero gating is registered alongside the RAM read, so the pair acts as one output register.
  assign bus.slot_byte   = rd_zero ? 8'h00 : ram_q;

  dmx_universe_ram u_ram (
    .clk   (CLK12),
    .we    (wr_accept),
    .waddr (bank_addr(~front, bus.wr_addr[SLOT_ADDR_W-2:0])),
    .wdata (bus.wr_data),
    .raddr (bank_addr(front, bus.slot_count[SLOT_ADDR_W-2:0])),
    .rdata (ram_q)
  );

  // Commit state register.
  always_ff @(posedge CLK12) begin
    if (reset) state <= S_CM_IDLE;
    else       state <= state_nxt;
  end

  // Commit next-state: requests while pending coalesce; swap only on frame start.
  always_comb begin
    state_nxt = state;
    swap      = 1'b0;
    case (state)
      S_CM_IDLE: begin
        if (bus.commit_req) state_nxt = S_CM_PENDING;
      end
      S_CM_PENDING: begin
        if (frame_start) begin
          swap      = 1'b1;
          state_nxt = S_CM_IDLE;
        end
      end
      default: state_nxt = S_CM_IDLE;
    endcase
  end

  // Bank select, frame counter, watchdog, overrun flag and read gating.
  always_ff @(posedge CLK12) begin
    if (reset) begin
      front       <= 1'b0;
      prev_slot   <= '0;
      frame_count <= '0;
      stale_cnt   <= '0;
      stale       <= 1'b1;
      wr_overrun  <= 1'b0;
      rd_zero     <= 1'b1;
    end else begin
      prev_slot <= bus.slot_count;
      if (swap) front <= ~front;
      if (frame_start) frame_count <= frame_count + 16'd1;
      if (swap) begin
        stale_cnt <= '0;
        stale     <= 1'b0;
      end else if (frame_start && (stale_cnt != STALE_MAX)) begin
        stale_cnt <= stale_cnt + 1'b1;
        if (stale_cnt == STALE_MAX - 1'b1) stale <= 1'b1;
      end
      if (bus.wr_en && !wr_ready) wr_overrun <= 1'b1;
      rd_zero <= blackout || (STALE_BLACKOUT && stale) ||
                 (bus.slot_count == '0) || (bus.slot_count >= SLOT_END);
    end
  end

endmodule
